// File: rtl/ahb_arbiter_pkg.sv
// ahb_arbiter_pkg
//   Shared types and helpers for the AHB bus arbiter.
//   - htrans_e    : AHB HTRANS encodings.
//   - hburst_e    : AHB HBURST encodings.
//   - arb_state_e : arbiter FSM states.
//   - burst_beats : beat count of a burst type (0 = undefined-length INCR).
package ahb_arbiter_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Width of the beat counter: holds up to 15 remaining beats.
  localparam int CNT_W = 4;

  function automatic logic [4:0] burst_beats(input hburst_e hb);
    logic [4:0] beats;
    case (hb)
      HB_SINGLE:           beats = 5'd1;
      HB_INCR:             beats = 5'd0;
      HB_WRAP4, HB_INCR4:  beats = 5'd4;
      HB_WRAP8, HB_INCR8:  beats = 5'd8;
      default:             beats = 5'd16;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// ahb_arbiter_rr_pick
//   Combinational round-robin picker. The search starts at last+1 and wraps
//   modulo MST, so the previous owner is considered last.
//   Ports:
//     req   [MST] in  : request vector
//     last  [MW]  in  : index of the previous owner
//     gnt   [MST] out : one-hot winner (all zero when nobody requests)
//     valid       out : at least one request was present
module ahb_arbiter_rr_pick #(
  parameter int MST = 2,
  parameter int MW  = 1
) (
  input  logic [MST-1:0] req,
  input  logic [MW-1:0]  last,
  output logic [MST-1:0] gnt,
  output logic           valid
);

  logic [MW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= MST; k++) begin
      idx = MW'((int'(last) + k) % MST);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Multi-master AHB arbiter: one-hot registered grant, address-phase and
//   data-phase owner indices for the fabric muxes, fixed-length burst
//   holding and bus parking on DEFAULT_MST.
//   Optional feature macro: AHB_ARBITER_LOCK_EN (locked transfers). Without
//   it hlock is ignored and hmastlock is tied low.
//   Ports:
//     clk           in        : clock
//     reset         in        : synchronous active-high reset
//     hbusreq [MST] in        : per-master bus request
//     hlock   [MST] in        : per-master lock request
//     htrans  [2]   in        : muxed address-phase HTRANS
//     hburst  [3]   in        : muxed address-phase HBURST
//     hready        in        : fabric HREADY
//     hgrant  [MST] out       : one-hot grant (registered)
//     hmaster [MW]  out       : address-phase owner
//     hmaster_data [MW] out   : data-phase owner
//     hmastlock     out       : current address phase is locked
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int MST         = 2,
  parameter int DEFAULT_MST = 0,
  parameter int MW          = (MST > 1) ? $clog2(MST) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [MST-1:0] hbusreq,
  input  logic [MST-1:0] hlock,
  input  logic [1:0]     htrans,
  input  logic [2:0]     hburst,
  input  logic           hready,
  output logic [MST-1:0] hgrant,
  output logic [MW-1:0]  hmaster,
  output logic [MW-1:0]  hmaster_data,
  output logic           hmastlock
);

  if (MST < 1 || MST > 8) begin : g_bad_mst
    $fatal(1, "ahb_arbiter: MST must be 1..8");
  end
  if (DEFAULT_MST < 0 || DEFAULT_MST >= MST) begin : g_bad_default
    $fatal(1, "ahb_arbiter: DEFAULT_MST must be < MST");
  end

  localparam logic [MST-1:0] DEF_GNT = MST'(1) << DEFAULT_MST;

  arb_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [MST-1:0]   grant_reg, grant_next;
  logic [MW-1:0]    master_reg, master_data_reg;

  logic [MW-1:0]    gnt_idx;
  logic [MST-1:0]   pick_gnt, arb_gnt;
  logic             pick_valid;
  logic             do_arb;
  htrans_e          trans;
  logic [4:0]       beats;
  logic             fixed;
  logic [CNT_W-1:0] beats_m1;

  assign trans    = htrans_e'(htrans);
  assign beats    = burst_beats(hburst_e'(hburst));
  assign fixed    = (beats > 5'd1);
  assign beats_m1 = CNT_W'(beats - 5'd1);

  // One-hot grant to index; the grant is always one-hot so OR-ing is exact.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < MST; i++) begin
      if (grant_reg[i]) gnt_idx = gnt_idx | MW'(i);
    end
  end

  ahb_arbiter_rr_pick #(
    .MST (MST),
    .MW  (MW)
  ) u_pick (
    .req   (hbusreq),
    .last  (master_reg),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Nobody requesting parks the bus on the default master.
  assign arb_gnt = pick_valid ? pick_gnt : DEF_GNT;

`ifdef AHB_ARBITER_LOCK_EN
  logic owner_lock;
  assign owner_lock = hlock[gnt_idx];
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    do_arb     = 1'b0;

    case (state_reg)
      ARB: do_arb = 1'b1;
      BURST: begin
        if (hready) begin
          if (trans == HT_SEQ) begin
            // Last beat: the counter reaches 0 and the grant is re-evaluated.
            if (cnt_reg == CNT_W'(1)) do_arb = 1'b1;
            else                      cnt_next = cnt_reg - CNT_W'(1);
          end else if (trans == HT_IDLE || trans == HT_NONSEQ) begin
            // Early termination: fall back to ARB and re-arbitrate now.
            do_arb = 1'b1;
          end
        end
      end
`ifdef AHB_ARBITER_LOCK_EN
      LOCKED: begin
        if (hready) begin
          if (!owner_lock && (trans == HT_IDLE || trans == HT_NONSEQ)) begin
            do_arb = 1'b1;
          end else if (trans == HT_SEQ && cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
          end else if (trans == HT_NONSEQ) begin
            cnt_next = fixed ? beats_m1 : '0;
          end else if (trans == HT_IDLE) begin
            cnt_next = '0;
          end
        end
      end
`endif
      default: do_arb = 1'b1;
    endcase

    // Arbitration point: take the round-robin winner unless the current
    // address phase starts a locked sequence or a fixed-length burst, in
    // which case the grant is frozen.
    if (do_arb) begin
      state_next = ARB;
      cnt_next   = '0;
      grant_next = arb_gnt;
      if (hready && trans == HT_NONSEQ) begin
`ifdef AHB_ARBITER_LOCK_EN
        if (owner_lock) begin
          state_next = LOCKED;
          grant_next = grant_reg;
          cnt_next   = fixed ? beats_m1 : '0;
        end else
`endif
        if (fixed) begin
          state_next = BURST;
          grant_next = grant_reg;
          cnt_next   = beats_m1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ARB;
      cnt_reg         <= '0;
      grant_reg       <= DEF_GNT;
      master_reg      <= MW'(DEFAULT_MST);
      master_data_reg <= MW'(DEFAULT_MST);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      if (hready) begin
        master_reg      <= gnt_idx;
        master_data_reg <= master_reg;
      end
    end
  end

`ifdef AHB_ARBITER_LOCK_EN
  logic mastlock_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      mastlock_reg <= 1'b0;
    end else if (hready) begin
      mastlock_reg <= owner_lock;
    end
  end
  assign hmastlock = mastlock_reg;
`else
  logic unused_hlock;
  assign unused_hlock = ^hlock;
  assign hmastlock    = 1'b0;
`endif

  assign hgrant       = grant_reg;
  assign hmaster      = master_reg;
  assign hmaster_data = master_data_reg;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter
//   Bench for ahb_arbiter: a 2-master and a 4-master instance share the
//   transfer-control inputs. A behavioural model (owner index, burst beats
//   left, mode) predicts every output each cycle; directed sequences pin
//   the model with literal expectations. Honours AHB_ARBITER_LOCK_EN.
module tb_ahb_arbiter;

`ifdef AHB_ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] req2, lock2;
  logic [3:0] req4, lock4;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;

  logic [1:0] hgrant2;
  logic       hmaster2, hmaster_data2, hmastlock2;
  logic [3:0] hgrant4;
  logic [1:0] hmaster4, hmaster_data4;
  logic       hmastlock4;

  int n_checks = 0;
  int n_errors = 0;

  ahb_arbiter #(.MST(2), .DEFAULT_MST(0)) dut2 (
    .clk(clk), .reset(reset), .hbusreq(req2), .hlock(lock2),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant2), .hmaster(hmaster2), .hmaster_data(hmaster_data2),
    .hmastlock(hmastlock2)
  );

  ahb_arbiter #(.MST(4), .DEFAULT_MST(0)) dut4 (
    .clk(clk), .reset(reset), .hbusreq(req4), .hlock(lock4),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant4), .hmaster(hmaster4), .hmaster_data(hmaster_data4),
    .hmastlock(hmastlock4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = free arbitration, 1 = inside a fixed burst, 2 = locked
  typedef struct {
    int owner;     // index of the granted master
    int amaster;   // address-phase owner
    int dmaster;   // data-phase owner
    int mlock;     // address phase locked
    int mode;
    int left;      // beats still to come in the current burst
  } mdl_t;

  function automatic mdl_t model_reset(input int d);
    mdl_t r;
    r.owner = d; r.amaster = d; r.dmaster = d;
    r.mlock = 0; r.mode = 0; r.left = 0;
    return r;
  endfunction

  function automatic int beats_of(input int hb);
    if (hb == 0) return 1;
    if (hb == 1) return 0;
    return 4 << ((hb - 2) / 2);
  endfunction

  function automatic mdl_t model_next(input mdl_t o, input int m, input int d,
                                      input int req, input int lck, input int tr,
                                      input int hb, input bit rdy);
    mdl_t n;
    int   winner;
    int   beats;
    bit   arb;
    bit   own_lock;
    n        = o;
    beats    = beats_of(hb);
    own_lock = LOCK_EN && (((lck >> o.owner) & 1) == 1);
    winner   = d;
    for (int k = m; k >= 1; k--) begin
      // scanning backwards keeps the nearest requester after the owner
      if (((req >> ((o.amaster + k) % m)) & 1) == 1) winner = (o.amaster + k) % m;
    end
    if (rdy) begin
      n.amaster = o.owner;
      n.dmaster = o.amaster;
      n.mlock   = own_lock ? 1 : 0;
    end
    arb = 1'b0;
    if (o.mode == 0) arb = 1'b1;
    else if (o.mode == 1 && rdy) begin
      if (tr == 3) begin
        if (o.left == 1) arb = 1'b1;
        else n.left = o.left - 1;
      end else if (tr == 0 || tr == 2) arb = 1'b1;
    end else if (o.mode == 2 && rdy) begin
      if (!own_lock && (tr == 0 || tr == 2)) arb = 1'b1;
      else if (tr == 3 && o.left > 0) n.left = o.left - 1;
      else if (tr == 2) n.left = (beats > 1) ? beats - 1 : 0;
      else if (tr == 0) n.left = 0;
    end
    if (arb) begin
      n.mode = 0; n.left = 0; n.owner = winner;
      if (rdy && tr == 2) begin
        if (own_lock) begin
          n.mode = 2; n.owner = o.owner; n.left = (beats > 1) ? beats - 1 : 0;
        end else if (beats > 1) begin
          n.mode = 1; n.owner = o.owner; n.left = beats - 1;
        end
      end
    end
    return n;
  endfunction

  mdl_t m2, m4;

  always @(posedge clk) begin
    if (reset) begin
      m2 <= model_reset(0);
      m4 <= model_reset(0);
    end else begin
      m2 <= model_next(m2, 2, 0, int'(req2), int'(lock2), int'(htrans), int'(hburst), hready);
      m4 <= model_next(m4, 4, 0, int'(req4), int'(lock4), int'(htrans), int'(hburst), hready);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m2_hgrant",       int'(hgrant2),       1 << m2.owner);
    check("m2_hmaster",      int'(hmaster2),      m2.amaster);
    check("m2_hmaster_data", int'(hmaster_data2), m2.dmaster);
    check("m2_hmastlock",    int'(hmastlock2),    m2.mlock);
    check("m4_hgrant",       int'(hgrant4),       1 << m4.owner);
    check("m4_hmaster",      int'(hmaster4),      m4.amaster);
    check("m4_hmaster_data", int'(hmaster_data4), m4.dmaster);
    check("m4_hmastlock",    int'(hmastlock4),    m4.mlock);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; htrans = 2'd0; hburst = 3'd0; hready = 1'b1;
    lock2 = '0; lock4 = '0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  int hseq[$];
  int prev;
  int exp_rr[5];
  int s;

  initial begin
    reset = 1'b1; req2 = 2'b11; req4 = 4'hF; lock2 = '0; lock4 = '0;
    htrans = 2'd0; hburst = 3'd0; hready = 1'b1;

    // 1. reset held 3 cycles with both requesting
    repeat (3) step();
    check("rst_hgrant", int'(hgrant2), 1);
    check("rst_hmaster", int'(hmaster2), 0);
    check("rst_hmaster_data", int'(hmaster_data2), 0);
    check("rst_hmastlock", int'(hmastlock2), 0);
    reset = 1'b0;
    step();
    check("first_grant", int'(hgrant2), 2);
    $display("txn reset: hgrant=%b hmaster=%0d", hgrant2, hmaster2);

    // 2. idle parking
    do_reset();
    req2 = 2'b10;
    step();
    check("park_grant1", int'(hgrant2), 2);
    check("park_master0", int'(hmaster2), 0);
    req2 = 2'b00;
    step();
    check("park_grant_def", int'(hgrant2), 1);
    check("park_master1", int'(hmaster2), 1);
    step();
    check("park_master_back", int'(hmaster2), 0);
    check("park_mdata", int'(hmaster_data2), 1);
    $display("txn parking: hgrant=%b hmaster=%0d", hgrant2, hmaster2);

    // 3. INCR8 by master 0 with hready toggling
    do_reset();
    req2 = 2'b01;
    step(); step();
    check("b8_pre_grant", int'(hgrant2), 1);
    htrans = 2'd2; hburst = 3'd5; req2 = 2'b11;
    step();
    check("b8_nonseq_grant", int'(hgrant2), 1);
    htrans = 2'd3;
    for (s = 1; s <= 7; s++) begin
      hready = 1'b0;
      step();
      check("b8_wait_grant", int'(hgrant2), 1);
      hready = 1'b1;
      step();
      check("b8_beat_grant", int'(hgrant2), (s == 7) ? 2 : 1);
    end
    htrans = 2'd0;
    $display("txn incr8: handover hgrant=%b", hgrant2);

    // 4. WRAP4 by master 1 terminated early by IDLE
    do_reset();
    req2 = 2'b10;
    step(); step();
    check("w4_pre_master", int'(hmaster2), 1);
    htrans = 2'd2; hburst = 3'd2; req2 = 2'b11;
    step();
    check("w4_nonseq_grant", int'(hgrant2), 2);
    htrans = 2'd3;
    step();
    check("w4_seq_grant", int'(hgrant2), 2);
    htrans = 2'd0;
    step();
    check("w4_early_grant", int'(hgrant2), 1);
    $display("txn wrap4 early end: hgrant=%b", hgrant2);

    // 5. round-robin fairness, 4 masters all requesting, SINGLE
    do_reset();
    req4 = 4'hF; htrans = 2'd2; hburst = 3'd0;
    prev = int'(hmaster4);
    for (int i = 0; i < 12; i++) begin
      step();
      if (int'(hmaster4) != prev) hseq.push_back(int'(hmaster4));
      prev = int'(hmaster4);
    end
    exp_rr = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      check("rr_order", (hseq.size() > i) ? hseq[i] : -1, exp_rr[i]);
    end
    $display("txn round robin: %0d owner changes", hseq.size());

    // 6. locked INCR by master 1
    do_reset();
    req2 = 2'b10; htrans = 2'd0;
    step(); step();
    lock2 = 2'b10; htrans = 2'd2; hburst = 3'd1; req2 = 2'b11;
    step();
`ifdef AHB_ARBITER_LOCK_EN
    check("lk_nonseq_grant", int'(hgrant2), 2);
    check("lk_mastlock", int'(hmastlock2), 1);
    htrans = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lk_seq_grant", int'(hgrant2), 2);
    end
    lock2 = 2'b00; htrans = 2'd0;
    step();
    check("lk_release_grant", int'(hgrant2), 1);
`else
    check("nolk_grant", int'(hgrant2), 1);
    check("nolk_mastlock", int'(hmastlock2), 0);
    htrans = 2'd3;
    repeat (3) step();
    lock2 = 2'b00; htrans = 2'd0;
    step();
`endif
    $display("txn lock: hgrant=%b hmastlock=%0d", hgrant2, hmastlock2);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset  = ($urandom_range(0, 199) == 0);
      req2   = 2'($urandom);
      req4   = 4'($urandom);
      lock2  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      lock4  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      r      = $urandom_range(0, 9);
      htrans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 4) ? 2'd2 : 2'd3;
      hburst = 3'($urandom);
      hready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0;
    $display("txn random: 4000 cycles");

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
